// File: rtl/image_tx_scheduler.sv
// Round-robin scheduler sharing one Arduino image link among N_SRC frame sources.
// Optional: define IMAGE_TX_TIMEOUT_EN to add SEND timeout with retry and err reporting.
module image_tx_scheduler #(
  parameter int unsigned N_SRC      = 3,
  parameter int unsigned PULSE_TIME = 50_000_000,
  parameter int unsigned GAP_TIME   = 50_000_000,
  parameter int unsigned TIMEOUT    = 250_000_000,
  parameter int unsigned MAX_RETRY  = 2,
  localparam int unsigned SEL_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] req,
  input  logic             image_ready,
  output logic [N_SRC-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             reset_signal,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CNT_W = 28;

  typedef enum logic [1:0] {IDLE, PULSE, SEND, GAP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [SEL_W-1:0] last_winner, last_winner_next;
  logic [N_SRC-1:0] grant_next;
  logic [SEL_W-1:0] sel_next;
  logic             reset_signal_next;
  logic             busy_next;
  logic             done_next;

  logic             any_req;
  logic [SEL_W-1:0] winner;
  logic [N_SRC-1:0] winner_onehot;
  logic [SEL_W-1:0] cand;
  int               cand_i;

`ifdef IMAGE_TX_TIMEOUT_EN
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RETRY_W-1:0] retry, retry_next;
  logic               err_next;
  logic               timeout_hit;

  assign timeout_hit = (count == CNT_W'(TIMEOUT - 1));
`else
  // Timeout parameters are meaningless without the timeout logic.
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT[0], MAX_RETRY[0]};
  assign err = 1'b0;
`endif

  // Round-robin pick: first set req bit at or after last_winner+1, wrapping.
  always_comb begin
    any_req       = 1'b0;
    winner        = '0;
    winner_onehot = '0;
    cand_i        = 0;
    cand          = '0;
    for (int k = 0; k < int'(N_SRC); k++) begin
      cand_i = (int'(last_winner) + 1 + k) % int'(N_SRC);
      cand   = SEL_W'(cand_i);
      if (!any_req && req[cand]) begin
        any_req             = 1'b1;
        winner              = cand;
        winner_onehot[cand] = 1'b1;
      end
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_next        = state;
    grant_next        = grant;
    sel_next          = sel;
    reset_signal_next = 1'b1;
    busy_next         = 1'b1;
    done_next         = 1'b0;
    last_winner_next  = last_winner;
`ifdef IMAGE_TX_TIMEOUT_EN
    retry_next        = retry;
    err_next          = 1'b0;
`endif
    case (state)
      IDLE: begin
        busy_next  = 1'b0;
        grant_next = '0;
        sel_next   = '0;
        if (any_req) begin
          state_next        = PULSE;
          grant_next        = winner_onehot;
          sel_next          = winner;
          reset_signal_next = 1'b0;
          busy_next         = 1'b1;
        end
      end
      PULSE: begin
        reset_signal_next = 1'b0;
        if (count == CNT_W'(PULSE_TIME - 1)) begin
          state_next        = SEND;
          reset_signal_next = 1'b1;
        end
      end
      SEND: begin
        if (image_ready) begin
          state_next       = GAP;
          grant_next       = '0;
          sel_next         = '0;
          done_next        = 1'b1;
          last_winner_next = sel;
`ifdef IMAGE_TX_TIMEOUT_EN
          retry_next       = '0;
`endif
        end
`ifdef IMAGE_TX_TIMEOUT_EN
        else if (timeout_hit) begin
          if (retry < RETRY_W'(MAX_RETRY)) begin
            state_next        = PULSE;
            retry_next        = retry + RETRY_W'(1);
            reset_signal_next = 1'b0;
          end else begin
            state_next       = GAP;
            grant_next       = '0;
            sel_next         = '0;
            err_next         = 1'b1;
            last_winner_next = sel;
            retry_next       = '0;
          end
        end
`endif
      end
      GAP: begin
        grant_next = '0;
        sel_next   = '0;
        if (count == CNT_W'(GAP_TIME - 1)) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        sel_next   = '0;
        busy_next  = 1'b0;
      end
    endcase
    // Counter restarts on every state entry, including SEND -> PULSE retries.
    count_next = (state_next != state) ? '0 : count + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      last_winner  <= SEL_W'(N_SRC - 1);
      grant        <= '0;
      sel          <= '0;
      reset_signal <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef IMAGE_TX_TIMEOUT_EN
      retry        <= '0;
      err          <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      count        <= count_next;
      last_winner  <= last_winner_next;
      grant        <= grant_next;
      sel          <= sel_next;
      reset_signal <= reset_signal_next;
      busy         <= busy_next;
      done         <= done_next;
`ifdef IMAGE_TX_TIMEOUT_EN
      retry        <= retry_next;
      err          <= err_next;
`endif
    end
  end

endmodule

// File: tb/tb_image_tx_scheduler.sv
// Directed self-checking bench for image_tx_scheduler (N_SRC=3, PULSE=4, GAP=3, TIMEOUT=10, MAX_RETRY=1).
module tb_image_tx_scheduler;

  localparam int unsigned N_SRC = 3;
  localparam int unsigned SEL_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_SRC-1:0] req;
  logic             image_ready;
  logic [N_SRC-1:0] grant;
  logic [SEL_W-1:0] sel;
  logic             reset_signal;
  logic             busy;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;

  image_tx_scheduler #(
    .N_SRC(3), .PULSE_TIME(4), .GAP_TIME(3), .TIMEOUT(10), .MAX_RETRY(1)
  ) u_dut (
    .clk(clk), .reset(reset), .req(req), .image_ready(image_ready),
    .grant(grant), .sel(sel), .reset_signal(reset_signal),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 60) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; image_ready = 1'b0;
    tick(); tick();
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", grant); end
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
    checks++; if (reset_signal !== 1'b1) begin errors++; $display("FAIL reset_rs: got %b expected 1", reset_signal); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int low, cyc, donecnt;
    req = 3'b001;
    tick();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL single_grant: got %b expected 001", grant); end
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL single_sel: got %0d expected 0", sel); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    low = 0;
    for (int i = 0; i < 20 && reset_signal == 1'b0; i++) begin
      low++;
      tick();
    end
    checks++; if (low != 4) begin errors++; $display("FAIL single_pulse_len: got %0d expected 4", low); end
    tick();
    image_ready = 1'b1;
    tick();
    image_ready = 1'b0; req = '0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: got %b expected 1", done); end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL single_gap_grant: got %b expected 000", grant); end
    donecnt = 0; cyc = 0;
    while (busy && cyc < 20) begin
      if (done) donecnt++;
      tick();
      cyc++;
    end
    checks++; if (donecnt != 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", donecnt); end
    checks++; if (cyc != 3) begin errors++; $display("FAIL single_busy_tail: got %0d expected 3", cyc); end
  endtask

  task automatic test_round_robin();
    logic [N_SRC-1:0] exp_g [3];
    int cyc;
    exp_g = '{3'b001, 3'b010, 3'b100};
    reset = 1'b1; tick(); reset = 1'b0;
    req = 3'b111;
    for (int t = 0; t < 3; t++) begin
      cyc = 0;
      while (grant == '0 && cyc < 20) begin tick(); cyc++; end
      checks++; if (grant !== exp_g[t]) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", t, grant, exp_g[t]); end
      checks++; if (sel !== SEL_W'(t)) begin errors++; $display("FAIL rr_sel%0d: got %0d expected %0d", t, sel, t); end
      while (!reset_signal && cyc < 40) begin tick(); cyc++; end
      image_ready = 1'b1;
      tick();
      image_ready = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rr_done%0d: got %b expected 1", t, done); end
    end
    req = '0;
    wait_idle(cyc);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_req_drop();
    logic held;
    int cyc;
    req = 3'b010;
    tick();
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL drop_grant: got %b expected 010", grant); end
    tick();
    req = '0;
    held = 1'b1; cyc = 0;
    while (!reset_signal && cyc < 20) begin
      if (grant !== 3'b010) held = 1'b0;
      tick();
      cyc++;
    end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL drop_held_pulse: got %b expected 1", held); end
    checks++; if (grant !== 3'b010 || sel !== 2'd1) begin errors++; $display("FAIL drop_send_owner: got grant=%b sel=%0d expected 010/1", grant, sel); end
    image_ready = 1'b1;
    tick();
    image_ready = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL drop_done: got %b expected 1", done); end
    wait_idle(cyc);
    checks++; if (cyc != 3) begin errors++; $display("FAIL drop_gap_len: got %0d expected 3", cyc); end
  endtask

  task automatic test_reset_mid();
    int bad;
    req = 3'b001;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; req = '0;
    checks++; if (reset_signal !== 1'b1) begin errors++; $display("FAIL mid_rs: got %b expected 1", reset_signal); end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL mid_grant: got %b expected 000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || err || !reset_signal || busy) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_quiet: got %0d bad cycles expected 0", bad); end
  endtask

`ifdef IMAGE_TX_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, low, send, errcnt, donecnt, err_with_grant;
    req = 3'b001;
    tick();
    req = '0;
    cyc = 0; low = 0; send = 0; errcnt = 0; donecnt = 0; err_with_grant = 0;
    while (busy && cyc < 100) begin
      if (!reset_signal) low++;
      if (reset_signal && grant != '0) send++;
      if (err) begin errcnt++; if (grant != '0) err_with_grant++; end
      if (done) donecnt++;
      tick();
      cyc++;
    end
    checks++; if (low != 8) begin errors++; $display("FAIL to_pulse_cycles: got %0d expected 8", low); end
    checks++; if (send != 20) begin errors++; $display("FAIL to_send_cycles: got %0d expected 20", send); end
    checks++; if (errcnt != 1) begin errors++; $display("FAIL to_err_count: got %0d expected 1", errcnt); end
    checks++; if (err_with_grant != 0) begin errors++; $display("FAIL to_err_in_gap: got %0d expected 0", err_with_grant); end
    checks++; if (donecnt != 0) begin errors++; $display("FAIL to_done_count: got %0d expected 0", donecnt); end
    checks++; if (cyc != 31) begin errors++; $display("FAIL to_busy_len: got %0d expected 31", cyc); end
  endtask

  task automatic test_timeout_race();
    int cyc, errcnt, low;
    req = 3'b001;
    tick();
    req = '0;
    cyc = 0;
    while (!reset_signal && cyc < 20) begin tick(); cyc++; end
    for (int i = 0; i < 9; i++) tick();
    image_ready = 1'b1;
    tick();
    image_ready = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL race_done: got %b expected 1", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL race_err: got %b expected 0", err); end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL race_grant: got %b expected 000", grant); end
    errcnt = 0; low = 0; cyc = 0;
    while (busy && cyc < 40) begin
      if (err) errcnt++;
      if (!reset_signal) low++;
      tick();
      cyc++;
    end
    checks++; if (errcnt != 0 || low != 0) begin errors++; $display("FAIL race_no_retry: got err=%0d low=%0d expected 0/0", errcnt, low); end
  endtask
`else
  task automatic test_no_timeout();
    logic ok;
    int cyc;
    req = 3'b001;
    tick();
    req = '0;
    cyc = 0;
    while (!reset_signal && cyc < 20) begin tick(); cyc++; end
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (grant !== 3'b001 || err !== 1'b0 || busy !== 1'b1 || reset_signal !== 1'b1) ok = 1'b0;
      tick();
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL nto_hold: got %b expected 1", ok); end
    image_ready = 1'b1;
    tick();
    image_ready = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL nto_done: got %b expected 1", done); end
    wait_idle(cyc);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nto_idle: got busy=%b expected 0", busy); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_req_drop();
    test_reset_mid();
`ifdef IMAGE_TX_TIMEOUT_EN
    test_timeout();
    test_timeout_race();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
